vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Single-port VRAM (8 KiB, CPU 0x8000-0x9FFF) arbiter/sequencer shared by the PPU BG/window fetcher,
//  the sprite fetcher and the CPU bus. Grants one access per clk, drives the synchronous VRAM macro,
//  routes read data back one cycle later. Enforces DMG mode-3 lockout: CPU sees 0xFF / writes dropped.
// PARAMETERS
//  ADDR_W      13   VRAM macro address width (byte addresses 0..8191)
//  LOCK_MODE3  1    1 = block CPU VRAM access while lcd_en && ppu_mode==3; 0 = never block (debug)
// PORTS
//  clk        in   1   clock
//  reset      in   1   asynchronous, active-high reset
//  lcd_en     in   1   LCDC.7
//  ppu_mode   in   2   current STAT mode (0 HBlank, 1 VBlank, 2 OAM, 3 transfer)
//  bg_req     in   1   BG fetcher read request; held until bg_gnt
//  bg_addr    in   16  BG fetcher CPU-space address
//  bg_gnt     out  1   BG request accepted this cycle (combinational)
//  bg_valid   out  1   bg_rdata valid (1 cycle after bg_gnt)
//  bg_rdata   out  8   BG read data
//  spr_req    in   1   sprite fetcher read request; held until spr_gnt
//  spr_addr   in   16  sprite fetcher CPU-space address
//  spr_gnt    out  1   sprite request accepted this cycle (combinational)
//  spr_valid  out  1   spr_rdata valid (1 cycle after spr_gnt)
//  spr_rdata  out  8   sprite read data
//  cpu_rd     in   1   CPU read strobe; held until cpu_ack
//  cpu_wr     in   1   CPU write strobe; held until cpu_ack (rd && wr together: wr wins)
//  cpu_addr   in   16  CPU address (decoder asserts strobes only for 0x8000-0x9FFF)
//  cpu_wdata  in   8   CPU write data
//  cpu_ack    out  1   CPU access complete; cpu_rdata valid same cycle for reads
//  cpu_rdata  out  8   CPU read data
//  mem_en     out  1   VRAM enable
//  mem_we     out  1   VRAM write enable
//  mem_addr   out  ADDR_W  VRAM address = requester addr[ADDR_W-1:0]
//  mem_wdata  out  8   VRAM write data
//  mem_rdata  in   8   VRAM read data, valid the cycle after mem_en && !mem_we
//  owner_dbg  out  2   registered owner of the in-flight read (0 none, 1 BG, 2 SPR, 3 CPU)
// BEHAVIOUR
//  - Reset: bg_valid, spr_valid and cpu_ack = 0; all rdata = 0xFF; owner_dbg = 0. mem_en, mem_we,
//    bg_gnt and spr_gnt are combinational and forced 0 while reset is high. In-flight read discarded.
//  - cpu_lock = LOCK_MODE3 && lcd_en && ppu_mode==3 (combinational, sampled every cycle).
//  - Per-cycle fixed priority: SPR > BG > CPU. At most one gnt per cycle. mem_* driven combinationally
//    from the winner. Losers keep req high and wait; no starvation guarantee is given to the CPU in mode 3.
//  - Fetcher grant: mem_en=1, mem_we=0. Owner register <= SPR/BG. Next cycle: <owner>_valid=1 and
//    <owner>_rdata <= mem_rdata. Back-to-back grants give a valid every cycle (throughput 1/clk).
//  - Out-of-range fetcher address (addr[15:13] != 3'b100): granted with mem_en=0; valid next cycle,
//    rdata=0xFF.
//  - CPU, unlocked, no fetcher request: write -> mem_en=mem_we=1 and cpu_ack in the same cycle.
//    Read -> mem_en=1, owner=CPU; next cycle cpu_ack=1, cpu_rdata=mem_rdata. CPU is not re-granted
//    while its own read is in flight (no duplicate access on a held strobe).
//  - CPU, locked: no VRAM access. Read -> cpu_ack next cycle with cpu_rdata=0xFF. Write -> dropped,
//    cpu_ack next cycle. A locked CPU access is acked even if fetchers are requesting.
//  - Mode change mid-read: an in-flight granted read always completes with real data, even if
//    cpu_lock rises on the return cycle.
//  - *_valid and cpu_ack are 1-cycle pulses; rdata holds its last value between pulses.
//  - reset asserted mid-operation: pending owner cleared; no valid/ack is produced for that access.
// TESTING
//  1. mode=2, cpu_wr 0x8010<=0x5A, then cpu_rd 0x8010 -> mem_we pulse at addr 0x010; ack 1 cyc later, rdata 0x5A.
//  2. mode=3, lcd_en=1, cpu_rd 0x8010 -> mem_en never high for CPU; cpu_ack next cycle, rdata 0xFF; cpu_wr dropped (readback later =0x5A).
//  3. mode=3, bg_req+spr_req same cycle -> spr_gnt first, bg_gnt next cycle; spr_valid then bg_valid on consecutive cycles.
//  4. bg_req held 8 consecutive cycles (0x9800..0x9807) -> 8 grants, 8 valids, each 1 cycle after grant, data matches preload.
//  5. cpu_rd granted at mode=2, ppu_mode->3 on return cycle -> cpu_ack with real data (not 0xFF).
//  6. reset pulsed while bg read in flight -> no bg_valid; all outputs at reset values; next bg_req served normally.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the PPU fetchers, the CPU VRAM window, the VRAM macro and the arbiter.
// The arbiter takes the slave modport; the surrounding fabric (or a bench) takes master.
interface vram_arbiter_if #(
   parameter int ADDR_W = 13
);
   logic              lcd_en;
   logic [1:0]        ppu_mode;

   logic              bg_req;
   logic [15:0]       bg_addr;
   logic              bg_gnt;
   logic              bg_valid;
   logic [7:0]        bg_rdata;

   logic              spr_req;
   logic [15:0]       spr_addr;
   logic              spr_gnt;
   logic              spr_valid;
   logic [7:0]        spr_rdata;

   logic              cpu_rd;
   logic              cpu_wr;
   logic [15:0]       cpu_addr;
   logic [7:0]        cpu_wdata;
   logic              cpu_ack;
   logic [7:0]        cpu_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   logic [1:0]        owner_dbg;

   modport slave (
      input  lcd_en, ppu_mode,
      input  bg_req, bg_addr,
      output bg_gnt, bg_valid, bg_rdata,
      input  spr_req, spr_addr,
      output spr_gnt, spr_valid, spr_rdata,
      input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
      output cpu_ack, cpu_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output owner_dbg
   );

   modport master (
      output lcd_en, ppu_mode,
      output bg_req, bg_addr,
      input  bg_gnt, bg_valid, bg_rdata,
      output spr_req, spr_addr,
      input  spr_gnt, spr_valid, spr_rdata,
      output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
      input  cpu_ack, cpu_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  owner_dbg
   );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: fixed priority SPR > BG > CPU, one access per clock,
// read data returned the cycle after the grant, CPU locked out during mode 3.
module vram_arbiter #(
   parameter int ADDR_W     = 13,
   parameter bit LOCK_MODE3 = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   vram_arbiter_if.slave   bus
);
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_BG   = 2'd1,
      OWN_SPR  = 2'd2,
      OWN_CPU  = 2'd3
   } owner_e;

   owner_e      r_owner, w_owner_nxt;
   logic        r_oor, w_oor_nxt;
   logic        r_lk_pend, w_lk_pend_nxt;
   logic        r_lk_rd, w_lk_rd_nxt;
   logic [7:0]  r_bg_hold, r_spr_hold, r_cpu_hold;

   logic        w_cpu_lock, w_cpu_req, w_cpu_busy;
   logic        w_spr_gnt, w_bg_gnt, w_cpu_gnt;
   logic        w_mem_en, w_mem_we;
   logic [15:0] w_addr;
   logic        w_bg_valid, w_spr_valid, w_cpu_rd_ret, w_lk_rd_ret;
   logic [7:0]  w_fetch_data;

   function automatic logic in_vram(input logic [15:0] a);
      return a[15:13] == 3'b100;
   endfunction

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned
   // and no latch is inferred.
   always_comb begin
      w_owner_nxt   = OWN_NONE;
      w_oor_nxt     = 1'b0;
      w_lk_pend_nxt = 1'b0;
      w_lk_rd_nxt   = 1'b0;
      w_spr_gnt     = 1'b0;
      w_bg_gnt      = 1'b0;
      w_cpu_gnt     = 1'b0;
      w_mem_en      = 1'b0;
      w_mem_we      = 1'b0;
      w_addr        = 16'h0000;
      w_cpu_lock    = LOCK_MODE3 && bus.lcd_en && (bus.ppu_mode == 2'd3);
      w_cpu_req     = bus.cpu_rd || bus.cpu_wr;
      // A held strobe must not be accepted again while its own ack is still outstanding.
      w_cpu_busy    = (r_owner == OWN_CPU) || r_lk_pend;

      if (!reset) begin
         if (w_cpu_req && !w_cpu_busy && w_cpu_lock) begin
            w_lk_pend_nxt = 1'b1;
            w_lk_rd_nxt   = !bus.cpu_wr;
         end

         if (bus.spr_req) begin
            w_spr_gnt   = 1'b1;
            w_owner_nxt = OWN_SPR;
            w_addr      = bus.spr_addr;
            w_mem_en    = in_vram(bus.spr_addr);
            w_oor_nxt   = !in_vram(bus.spr_addr);
         end else if (bus.bg_req) begin
            w_bg_gnt    = 1'b1;
            w_owner_nxt = OWN_BG;
            w_addr      = bus.bg_addr;
            w_mem_en    = in_vram(bus.bg_addr);
            w_oor_nxt   = !in_vram(bus.bg_addr);
         end else if (w_cpu_req && !w_cpu_busy && !w_cpu_lock) begin
            w_cpu_gnt   = 1'b1;
            w_addr      = bus.cpu_addr;
            w_mem_en    = 1'b1;
            w_mem_we    = bus.cpu_wr;
            w_owner_nxt = bus.cpu_wr ? OWN_NONE : OWN_CPU;
         end
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_owner   <= OWN_NONE;
         r_oor     <= 1'b0;
         r_lk_pend <= 1'b0;
         r_lk_rd   <= 1'b0;
      end else begin
         r_owner   <= w_owner_nxt;
         r_oor     <= w_oor_nxt;
         r_lk_pend <= w_lk_pend_nxt;
         r_lk_rd   <= w_lk_rd_nxt;
      end
   end

   assign w_bg_valid   = (r_owner == OWN_BG);
   assign w_spr_valid  = (r_owner == OWN_SPR);
   assign w_cpu_rd_ret = (r_owner == OWN_CPU);
   assign w_lk_rd_ret  = r_lk_pend && r_lk_rd;
   assign w_fetch_data = r_oor ? 8'hFF : bus.mem_rdata;

   // Returned data is presented on the pulse cycle and held afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bg_hold  <= 8'hFF;
         r_spr_hold <= 8'hFF;
         r_cpu_hold <= 8'hFF;
      end else begin
         if (w_bg_valid)   r_bg_hold  <= w_fetch_data;
         if (w_spr_valid)  r_spr_hold <= w_fetch_data;
         if (w_cpu_rd_ret) r_cpu_hold <= bus.mem_rdata;
         else if (w_lk_rd_ret) r_cpu_hold <= 8'hFF;
      end
   end

   assign bus.bg_gnt    = w_bg_gnt;
   assign bus.bg_valid  = w_bg_valid;
   assign bus.bg_rdata  = w_bg_valid ? w_fetch_data : r_bg_hold;
   assign bus.spr_gnt   = w_spr_gnt;
   assign bus.spr_valid = w_spr_valid;
   assign bus.spr_rdata = w_spr_valid ? w_fetch_data : r_spr_hold;

   assign bus.cpu_ack   = w_cpu_rd_ret || r_lk_pend || (w_cpu_gnt && bus.cpu_wr);
   assign bus.cpu_rdata = w_cpu_rd_ret ? bus.mem_rdata :
                          w_lk_rd_ret  ? 8'hFF : r_cpu_hold;

   assign bus.mem_en    = w_mem_en;
   assign bus.mem_we    = w_mem_we;
   assign bus.mem_addr  = w_addr[ADDR_W-1:0];
   assign bus.mem_wdata = w_mem_we ? bus.cpu_wdata : 8'h00;
   assign bus.owner_dbg = r_owner;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: VRAM behavioural model, shadow memory for expectations,
// per-requester scoreboard queues popped by a monitor on every valid/ack pulse.
module tb_vram_arbiter;
   localparam int ADDR_W = 13;

   logic clk;
   logic reset;
   int   cyc;
   int   n_asserts;
   int   n_fail;

   vram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   vram_arbiter #(.ADDR_W(ADDR_W), .LOCK_MODE3(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc++;

   // Synchronous VRAM macro stand-in and the bench's own view of what it should hold.
   logic [7:0] vram    [8192];
   logic [7:0] exp_mem [8192];
   logic [7:0] r_q;

   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) vram[bus.mem_addr] <= bus.mem_wdata;
         else            r_q <= vram[bus.mem_addr];
      end
   end
   assign bus.mem_rdata = r_q;

   typedef struct {
      logic [7:0] data;
      int         cyc;
      bit         is_rd;
   } exp_t;

   exp_t q_bg[$];
   exp_t q_spr[$];
   exp_t q_cpu[$];
   exp_t e;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every pulse must match the head of its queue.
   always @(negedge clk) begin
      #2;
      if (bus.bg_valid) begin
         if (q_bg.size() == 0) check("bg_valid_unexpected", 16'(bus.bg_valid), 16'h0);
         else begin
            e = q_bg.pop_front();
            check("bg_rdata", 16'(bus.bg_rdata), 16'(e.data));
            check("bg_valid_cycle", 16'(cyc), 16'(e.cyc));
         end
      end
      if (bus.spr_valid) begin
         if (q_spr.size() == 0) check("spr_valid_unexpected", 16'(bus.spr_valid), 16'h0);
         else begin
            e = q_spr.pop_front();
            check("spr_rdata", 16'(bus.spr_rdata), 16'(e.data));
            check("spr_valid_cycle", 16'(cyc), 16'(e.cyc));
         end
      end
      if (bus.cpu_ack) begin
         if (q_cpu.size() == 0) check("cpu_ack_unexpected", 16'(bus.cpu_ack), 16'h0);
         else begin
            e = q_cpu.pop_front();
            if (e.is_rd) check("cpu_rdata", 16'(bus.cpu_rdata), 16'(e.data));
         end
      end
   end

   // Fetcher read; expectation pushed on the grant cycle, valid due one cycle later.
   task automatic fetch(input bit spr, input logic [15:0] a);
      bit   got;
      exp_t x;
      got = 1'b0;
      if (spr) begin bus.spr_req = 1'b1; bus.spr_addr = a; end
      else     begin bus.bg_req  = 1'b1; bus.bg_addr  = a; end
      for (int i = 0; i < 20; i++) begin
         sample();
         if (spr ? bus.spr_gnt : bus.bg_gnt) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check(spr ? "spr_gnt_timeout" : "bg_gnt_timeout",
                      16'(spr ? bus.spr_gnt : bus.bg_gnt), 16'h1);
      else begin
         if (a[15:13] == 3'b100) begin
            check("fetch_mem_en", 16'(bus.mem_en), 16'h1);
            check("fetch_mem_addr", 16'(bus.mem_addr), 16'(a[12:0]));
            x.data = exp_mem[a[12:0]];
         end else begin
            check("fetch_oor_mem_en", 16'(bus.mem_en), 16'h0);
            x.data = 8'hFF;
         end
         x.cyc   = cyc + 1;
         x.is_rd = 1'b1;
         if (spr) q_spr.push_back(x);
         else     q_bg.push_back(x);
      end
      next_cycle();
      bus.spr_req = 1'b0;
      bus.bg_req  = 1'b0;
   endtask

   // CPU access; lock_on_ret raises mode 3 right after an unlocked read is granted.
   task automatic cpu_access(input bit wr, input logic [15:0] a, input logic [7:0] d,
                             input bit locked, input bit lock_on_ret);
      exp_t x;
      bit   got;
      int   lat;
      got     = 1'b0;
      lat     = 0;
      x.is_rd = !wr;
      x.cyc   = -1;
      x.data  = locked ? 8'hFF : exp_mem[a[12:0]];
      if (wr && !locked) exp_mem[a[12:0]] = d;
      q_cpu.push_back(x);
      bus.cpu_rd    = !wr;
      bus.cpu_wr    = wr;
      bus.cpu_addr  = a;
      bus.cpu_wdata = d;
      for (int i = 0; i < 20; i++) begin
         sample();
         if (locked) check("cpu_locked_mem_en", 16'(bus.mem_en), 16'h0);
         if (bus.cpu_ack) begin
            got = 1'b1;
            lat = i;
            if (wr && !locked) begin
               check("cpu_wr_mem_we", 16'(bus.mem_we), 16'h1);
               check("cpu_wr_mem_addr", 16'(bus.mem_addr), 16'(a[12:0]));
               check("cpu_wr_mem_wdata", 16'(bus.mem_wdata), 16'(d));
            end
            break;
         end
         if (!locked && !wr && bus.mem_en) begin
            check("cpu_rd_mem_addr", 16'(bus.mem_addr), 16'(a[12:0]));
            if (lock_on_ret) begin
               next_cycle();
               bus.lcd_en   = 1'b1;
               bus.ppu_mode = 2'd3;
            end
         end
      end
      if (!got) check("cpu_ack_timeout", 16'(bus.cpu_ack), 16'h1);
      else      check("cpu_ack_latency", 16'(lat), (wr && !locked) ? 16'h0 : 16'h1);
      next_cycle();
      bus.cpu_rd = 1'b0;
      bus.cpu_wr = 1'b0;
   endtask

   initial begin
      n_asserts     = 0;
      n_fail        = 0;
      reset         = 1'b1;
      bus.lcd_en    = 1'b1;
      bus.ppu_mode  = 2'd2;
      bus.bg_req    = 1'b1;
      bus.bg_addr   = 16'h9800;
      bus.spr_req   = 1'b1;
      bus.spr_addr  = 16'h8000;
      bus.cpu_rd    = 1'b1;
      bus.cpu_wr    = 1'b0;
      bus.cpu_addr  = 16'h8000;
      bus.cpu_wdata = 8'h00;
      for (int i = 0; i < 8192; i++) begin
         vram[i]    = 8'(i * 7 + 3) ^ 8'(i >> 5);
         exp_mem[i] = 8'(i * 7 + 3) ^ 8'(i >> 5);
      end
      r_q = 8'h00;

      // Reset values, with every requester active to prove gating.
      repeat (2) @(posedge clk);
      sample();
      check("rst_bg_gnt", 16'(bus.bg_gnt), 16'h0);
      check("rst_spr_gnt", 16'(bus.spr_gnt), 16'h0);
      check("rst_mem_en", 16'(bus.mem_en), 16'h0);
      check("rst_mem_we", 16'(bus.mem_we), 16'h0);
      check("rst_cpu_ack", 16'(bus.cpu_ack), 16'h0);
      check("rst_bg_valid", 16'(bus.bg_valid), 16'h0);
      check("rst_spr_valid", 16'(bus.spr_valid), 16'h0);
      check("rst_bg_rdata", 16'(bus.bg_rdata), 16'hFF);
      check("rst_spr_rdata", 16'(bus.spr_rdata), 16'hFF);
      check("rst_cpu_rdata", 16'(bus.cpu_rdata), 16'hFF);
      check("rst_owner", 16'(bus.owner_dbg), 16'h0);
      bus.bg_req  = 1'b0;
      bus.spr_req = 1'b0;
      bus.cpu_rd  = 1'b0;
      next_cycle();
      reset = 1'b0;
      next_cycle();

      // Unlocked write then readback.
      cpu_access(1'b1, 16'h8010, 8'h5A, 1'b0, 1'b0);
      cpu_access(1'b0, 16'h8010, 8'h00, 1'b0, 1'b0);

      // Mode-3 lockout: read gives 0xFF, write is dropped.
      bus.ppu_mode = 2'd3;
      cpu_access(1'b0, 16'h8010, 8'h00, 1'b1, 1'b0);
      cpu_access(1'b1, 16'h8010, 8'h33, 1'b1, 1'b0);
      bus.ppu_mode = 2'd2;
      cpu_access(1'b0, 16'h8010, 8'h00, 1'b0, 1'b0);

      // Simultaneous fetcher requests in mode 3: SPR first, BG next, valids back to back.
      bus.ppu_mode = 2'd3;
      bus.spr_req  = 1'b1;
      bus.spr_addr = 16'h8123;
      bus.bg_req   = 1'b1;
      bus.bg_addr  = 16'h9A00;
      sample();
      check("pri_spr_gnt", 16'(bus.spr_gnt), 16'h1);
      check("pri_bg_gnt_blocked", 16'(bus.bg_gnt), 16'h0);
      e.data = exp_mem[13'h0123]; e.cyc = cyc + 1; e.is_rd = 1'b1;
      q_spr.push_back(e);
      next_cycle();
      bus.spr_req = 1'b0;
      sample();
      check("pri_bg_gnt", 16'(bus.bg_gnt), 16'h1);
      check("pri_spr_valid", 16'(bus.spr_valid), 16'h1);
      e.data = exp_mem[13'h1A00]; e.cyc = cyc + 1; e.is_rd = 1'b1;
      q_bg.push_back(e);
      next_cycle();
      bus.bg_req = 1'b0;
      sample();
      check("pri_bg_valid", 16'(bus.bg_valid), 16'h1);
      check("pri_spr_valid_pulse", 16'(bus.spr_valid), 16'h0);
      next_cycle();

      // BG streaming: eight consecutive grants, one valid per clock.
      bus.bg_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.bg_addr = 16'h9800 + 16'(i);
         sample();
         check("stream_bg_gnt", 16'(bus.bg_gnt), 16'h1);
         e.data = exp_mem[13'h1800 + 13'(i)]; e.cyc = cyc + 1; e.is_rd = 1'b1;
         q_bg.push_back(e);
         next_cycle();
      end
      bus.bg_req = 1'b0;
      next_cycle();

      // Out-of-range sprite fetch returns 0xFF without touching VRAM.
      fetch(1'b1, 16'h7000);
      next_cycle();

      // Read granted in mode 2 completes with real data although mode 3 begins on return.
      bus.lcd_en   = 1'b1;
      bus.ppu_mode = 2'd2;
      cpu_access(1'b0, 16'h8456, 8'h00, 1'b0, 1'b1);
      bus.ppu_mode = 2'd2;

      // Reset during an in-flight BG read: no valid, outputs back at reset values.
      bus.bg_req  = 1'b1;
      bus.bg_addr = 16'h9900;
      sample();
      check("rst_mid_bg_gnt", 16'(bus.bg_gnt), 16'h1);
      next_cycle();
      bus.bg_req = 1'b0;
      reset      = 1'b1;
      sample();
      check("rst_mid_bg_valid", 16'(bus.bg_valid), 16'h0);
      check("rst_mid_owner", 16'(bus.owner_dbg), 16'h0);
      check("rst_mid_bg_rdata", 16'(bus.bg_rdata), 16'hFF);
      check("rst_mid_cpu_rdata", 16'(bus.cpu_rdata), 16'hFF);
      next_cycle();
      reset = 1'b0;
      next_cycle();
      fetch(1'b0, 16'h9901);
      repeat (3) next_cycle();

      check("bg_queue_drained", 16'(q_bg.size()), 16'h0);
      check("spr_queue_drained", 16'(q_spr.size()), 16'h0);
      check("cpu_queue_drained", 16'(q_cpu.size()), 16'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule
